// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
// Contents:
//   state_e          sequencer state encoding (RESET, SYNC, RELEASE, RUN, HALT)
//   DEF_*            default values for the rst_seq_ctrl parameters
package rst_seq_pkg;

    typedef enum logic [2:0] {
        RESET   = 3'd0,
        SYNC    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        HALT    = 3'd4
    } state_e;

    localparam int DEF_N_DOM       = 3;
    localparam int DEF_GAP         = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CYC_W       = 32;
    localparam int DEF_CYC_LIMIT   = 1000;

endpackage

// File: rtl/rst_sync.sv
// Reset-deassertion synchroniser: STAGES-deep flop chain, cleared
// asynchronously by rst and released synchronously to clk.
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   sclr        synchronous clear (restarts the chain without a hard reset)
//   rst_n_sync  synchronised active-low reset (last stage)
//   rst_n_pre   stage before the last; high one cycle before rst_n_sync
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclr,
    output logic rst_n_sync,
    output logic rst_n_pre
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else if (sclr) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_sync = chain[STAGES-1];
    assign rst_n_pre  = chain[STAGES-2];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and run supervisor for the processor under test.
// Synchronises reset deassertion, releases N_DOM reset domains in order
// (bit 0 first) spaced GAP cycles apart, then counts RUN cycles and halts
// on err or when the cycle count reaches CYC_LIMIT (0 = no timeout).
// Optional feature macro: RST_SEQ_SOFT_RST_EN adds soft_rst_req, which
// restarts the whole sequence from RUN or HALT.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   err           design error flag, sampled only in RUN
//   soft_rst_req  soft restart request (RST_SEQ_SOFT_RST_EN builds only)
//   dom_rst       per-domain reset, active high
//   run           design executing
//   halted        sticky, HALT entered
//   timeout       sticky, cycle limit reached
//   err_seen      sticky, err sampled high in RUN
//   cycle_cnt     RUN cycles so far, saturating
//
// state   | meaning
// RESET   | held in reset; all domains asserted
// SYNC    | waiting for reset deassertion to pass the synchroniser
// RELEASE | releasing domains one at a time, GAP cycles apart
// RUN     | design executing, cycles counted, err/limit watched
// HALT    | stopped; flags and count frozen until reset
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_DOM       = DEF_N_DOM,
    parameter int GAP         = DEF_GAP,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CYC_W       = DEF_CYC_W,
    parameter int CYC_LIMIT   = DEF_CYC_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err,
`ifdef RST_SEQ_SOFT_RST_EN
    input  logic             soft_rst_req,
`endif
    output logic [N_DOM-1:0] dom_rst,
    output logic             run,
    output logic             halted,
    output logic             timeout,
    output logic             err_seen,
    output logic [CYC_W-1:0] cycle_cnt
);

    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
    localparam logic [CYC_W-1:0] LIMIT    = CYC_W'(CYC_LIMIT);
    localparam bit               LIMIT_EN = (CYC_LIMIT != 0);

    state_e           state;
    logic [GAP_W-1:0] gap_cnt;
    logic             rst_n_sync;
    logic             rst_n_pre;
    logic             soft_clr;
    logic [N_DOM-1:0] dom_next;
    logic             last_step;
    logic [CYC_W-1:0] cnt_next;
    logic             limit_hit;

`ifdef RST_SEQ_SOFT_RST_EN
    // Requests in SYNC/RELEASE are ignored; in RESET a held request keeps
    // the synchroniser cleared so the timing restarts once it drops.
    assign soft_clr = soft_rst_req && (state == RESET || state == RUN || state == HALT);
`else
    assign soft_clr = 1'b0;
`endif

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .rst        (rst),
        .sclr       (soft_clr),
        .rst_n_sync (rst_n_sync),
        .rst_n_pre  (rst_n_pre)
    );

    // Domains release from bit 0 upward, so shifting in zeros can never
    // release them out of order.
    assign dom_next  = dom_rst << 1;
    assign last_step = (dom_next == '0);
    assign cnt_next  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
    assign limit_hit = LIMIT_EN && (cnt_next == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RESET;
            gap_cnt   <= '0;
            dom_rst   <= '1;
            run       <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            err_seen  <= 1'b0;
            cycle_cnt <= '0;
        end else if (soft_clr) begin
            state     <= RESET;
            gap_cnt   <= '0;
            dom_rst   <= '1;
            run       <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            err_seen  <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                RESET: begin
                    state <= SYNC;
                end
                // Acting on the pre-final stage makes this register the
                // final synchroniser stage, so domain 0 releases on the
                // same edge the chain output rises.
                SYNC: begin
                    if (rst_n_pre) begin
                        dom_rst <= dom_next;
                        gap_cnt <= GAP_LOAD;
                        if (last_step) begin
                            run   <= 1'b1;
                            state <= RUN;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (rst_n_sync) begin
                        if (gap_cnt == '0) begin
                            dom_rst <= dom_next;
                            gap_cnt <= GAP_LOAD;
                            if (last_step) begin
                                run   <= 1'b1;
                                state <= RUN;
                            end
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                end
                RUN: begin
                    cycle_cnt <= cnt_next;
                    if (err) begin
                        err_seen <= 1'b1;
                    end
                    if (limit_hit) begin
                        timeout <= 1'b1;
                    end
                    if (err || limit_hit) begin
                        halted <= 1'b1;
                        run    <= 1'b0;
                        state  <= HALT;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;

    localparam int N   = 3;
    localparam int G   = 2;
    localparam int S   = 2;
    localparam int LIM = 1000;
    localparam int RE  = S + (N - 1) * G;   // edge that starts RUN
    localparam logic [38:0] RST_V = {3'b111, 4'b0000, 32'd0};

    logic        clk;
    logic        rst;
    logic        err;
    logic        nl_err;
    logic [2:0]  dom_rst, nl_dom_rst;
    logic        run, halted, timeout, err_seen;
    logic        nl_run, nl_halted, nl_timeout, nl_err_seen;
    logic [31:0] cycle_cnt, nl_cycle_cnt;
    logic [38:0] obs, nl_obs, exp_v;
`ifdef RST_SEQ_SOFT_RST_EN
    logic        soft_rst_req;
    logic        nl_soft;
`endif

    int vectors;
    int miscompares;
    int k_cnt;

    rst_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .err          (err),
`ifdef RST_SEQ_SOFT_RST_EN
        .soft_rst_req (soft_rst_req),
`endif
        .dom_rst      (dom_rst),
        .run          (run),
        .halted       (halted),
        .timeout      (timeout),
        .err_seen     (err_seen),
        .cycle_cnt    (cycle_cnt)
    );

    rst_seq_ctrl #(.CYC_LIMIT(0)) dut_nl (
        .clk          (clk),
        .rst          (rst),
        .err          (nl_err),
`ifdef RST_SEQ_SOFT_RST_EN
        .soft_rst_req (nl_soft),
`endif
        .dom_rst      (nl_dom_rst),
        .run          (nl_run),
        .halted       (nl_halted),
        .timeout      (nl_timeout),
        .err_seen     (nl_err_seen),
        .cycle_cnt    (nl_cycle_cnt)
    );

    assign obs    = {dom_rst, run, halted, timeout, err_seen, cycle_cnt};
    assign nl_obs = {nl_dom_rst, nl_run, nl_halted, nl_timeout, nl_err_seen, nl_cycle_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset deassertion (edge 1 = first posedge with rst high).
    always @(posedge clk or negedge rst) begin
        if (!rst) k_cnt <= 0;
        else      k_cnt <= k_cnt + 1;
    end

    // Reference: outputs after edge k, given the RUN edge index at which err
    // was first sampled high (0 = never) and the cycle limit (0 = none).
    function automatic logic [38:0] model(int k, int err_k, int limit);
        logic [2:0]  d;
        logic        r, h, t, e;
        logic [31:0] c;
        int          n, stop;
        for (int i = 0; i < N; i++) d[i] = (k < S + i * G);
        r = 1'b0; h = 1'b0; t = 1'b0; e = 1'b0; c = 32'd0;
        if (k >= RE) begin
            n = k - RE;
            stop = -1;
            if (limit > 0) stop = limit;
            if (err_k > 0 && (stop < 0 || err_k < stop)) stop = err_k;
            if (stop >= 0 && n >= stop) begin
                c = 32'(stop);
                h = 1'b1;
                e = (err_k == stop);
                t = (limit > 0 && limit == stop);
            end else begin
                c = 32'(n);
                r = 1'b1;
            end
        end
        return {d, r, h, t, e, c};
    endfunction

    task automatic do_release();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        err = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== RST_V) begin
            $display("FAIL reset_values obs=%h exp=%h", obs, RST_V);
            miscompares++;
        end
        vectors++;
        if (nl_obs !== RST_V) begin
            $display("FAIL reset_values_nl obs=%h exp=%h", nl_obs, RST_V);
            miscompares++;
        end
    endtask

    // err toggles randomly through SYNC/RELEASE (forced high on the last
    // release edge) and must be ignored.
    task automatic test_release();
        err = 1'($urandom_range(0, 1));
        do_release();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            exp_v = model(k_cnt, 0, LIM);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL release k=%0d obs=%h exp=%h", k_cnt, obs, exp_v);
                miscompares++;
            end
            if (k_cnt + 1 == RE)     err = 1'b1;
            else if (k_cnt + 1 < RE) err = 1'($urandom_range(0, 1));
            else                     err = 1'b0;
        end
    endtask

    // Continues from test_release through the limit and 20+ cycles beyond.
    task automatic test_timeout();
        err = 1'b0;
        repeat (RE + LIM + 25 - 14) begin
            @(negedge clk);
            exp_v = model(k_cnt, 0, LIM);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL timeout k=%0d obs=%h exp=%h", k_cnt, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_err(input int e);
        rst = 1'b0;
        err = 1'b0;
        @(negedge clk);
        do_release();
        for (int i = 0; i < RE + e + 15; i++) begin
            @(negedge clk);
            exp_v = model(k_cnt, e, LIM);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL err_at_%0d k=%0d obs=%h exp=%h", e, k_cnt, obs, exp_v);
                miscompares++;
            end
            if (k_cnt + 1 == RE + e)     err = 1'b1;
            else if (k_cnt + 1 > RE + e) err = 1'($urandom_range(0, 1));
            else                         err = 1'b0;
        end
        err = 1'b0;
    endtask

    task automatic test_mid_release_reset();
        rst = 1'b0;
        err = 1'b0;
        @(negedge clk);
        do_release();
        repeat (2) @(negedge clk);
        exp_v = model(k_cnt, 0, LIM);
        vectors++;
        if (obs !== exp_v) begin
            $display("FAIL mid_release_pre k=%0d obs=%h exp=%h", k_cnt, obs, exp_v);
            miscompares++;
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (obs !== RST_V) begin
            $display("FAIL async_reset obs=%h exp=%h", obs, RST_V);
            miscompares++;
        end
        do_release();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_v = model(k_cnt, 0, LIM);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL restart k=%0d obs=%h exp=%h", k_cnt, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_no_limit();
        rst = 1'b0;
        err = 1'b0;
        @(negedge clk);
        do_release();
        repeat (RE + 5010) begin
            @(negedge clk);
            exp_v = model(k_cnt, 0, 0);
            vectors++;
            if (nl_obs !== exp_v) begin
                $display("FAIL no_limit k=%0d obs=%h exp=%h", k_cnt, nl_obs, exp_v);
                miscompares++;
            end
            exp_v = model(k_cnt, 0, LIM);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL limit_long k=%0d obs=%h exp=%h", k_cnt, obs, exp_v);
                miscompares++;
            end
        end
    endtask

`ifdef RST_SEQ_SOFT_RST_EN
    task automatic test_soft_reset();
        int base;
        int e;
        e = 5;
        rst = 1'b0;
        err = 1'b0;
        @(negedge clk);
        do_release();
        repeat (RE + e + 3) begin
            @(negedge clk);
            err = (k_cnt + 1 == RE + e);
        end
        err = 1'b0;
        exp_v = model(k_cnt, e, LIM);
        vectors++;
        if (obs !== exp_v) begin
            $display("FAIL soft_pre_halt obs=%h exp=%h", obs, exp_v);
            miscompares++;
        end
        soft_rst_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (obs !== RST_V) begin
                $display("FAIL soft_hold obs=%h exp=%h", obs, RST_V);
                miscompares++;
            end
        end
        soft_rst_req = 1'b0;
        base = k_cnt;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_v = model(k_cnt - base, 0, LIM);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL soft_restart k=%0d obs=%h exp=%h", k_cnt - base, obs, exp_v);
                miscompares++;
            end
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        nl_err      = 1'b0;
`ifdef RST_SEQ_SOFT_RST_EN
        soft_rst_req = 1'b0;
        nl_soft      = 1'b0;
`endif
        test_reset();
        test_release();
        test_timeout();
        test_err(37);
        test_err(1);
        test_err(LIM);
        test_err(int'($urandom_range(2, 900)));
        test_mid_release_reset();
`ifdef RST_SEQ_SOFT_RST_EN
        test_soft_reset();
`endif
        test_no_limit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
